mdu_core: RTL and testbench

//  Multiply/divide unit executing the 4-bit MDU op codes produced by instruction decode.

---
 rtl/mdu_core_pkg.sv | 43 ++++
 rtl/mdu_core_if.sv | 23 ++
 rtl/mdu_divider.sv | 50 +++++
 rtl/mdu_core.sv | 154 +++++++++++++++
 tb/tb_mdu_core.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_core_pkg.sv
// Shared op codes, latched-operation context and op-class helpers for the multiply/divide unit.
package mdu_core_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_DIV   = 4'd1,
        MDU_OP_DIVU  = 4'd2,
        MDU_OP_MUL   = 4'd3,
        MDU_OP_MULT  = 4'd4,
        MDU_OP_MULTU = 4'd5,
        MDU_OP_MFHI  = 4'd6,
        MDU_OP_MFLO  = 4'd7,
        MDU_OP_MTHI  = 4'd8,
        MDU_OP_MTLO  = 4'd9
    } mdu_op_e;

    // Context captured at accept time and held for the whole iterative operation.
    typedef struct packed {
        mdu_op_e op;
        logic    neg_res;
        logic    neg_rem;
        logic    div_zero;
    } mdu_ctx_t;

    function automatic logic op_is_multi(input logic [OP_W-1:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_MUL, MDU_OP_MULT, MDU_OP_MULTU};
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_DIVU};
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_MUL, MDU_OP_MULT};
    endfunction

    function automatic logic op_is_move(input logic [OP_W-1:0] op);
        return op inside {MDU_OP_MFHI, MDU_OP_MFLO, MDU_OP_MTHI, MDU_OP_MTLO};
    endfunction

endpackage

// File: rtl/mdu_core_if.sv
// EX-stage issue/result bundle between the pipeline and the multiply/divide unit.
interface mdu_core_if #(parameter int unsigned WIDTH = 32);
    logic [3:0]       mdu_op_i;
    logic             start_i;
    logic             flush_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] result_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output mdu_op_i, start_i, flush_i, a_i, b_i,
        input  result_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  mdu_op_i, start_i, flush_i, a_i, b_i,
        output result_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_divider.sv
// Restoring unsigned divider, one quotient bit per enabled cycle; exposes the post-iteration values.
module mdu_divider #(parameter int unsigned WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_c,
    output logic [WIDTH-1:0] remainder_c,
    output logic             done_c
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   shifted_c;
    logic             ge_c;

    // A zero divisor always "fits", so the quotient fills with ones and the dividend shifts into rem.
    always_comb begin
        shifted_c   = {rem, quot[WIDTH-1]};
        ge_c        = (shifted_c >= {1'b0, dvsr});
        remainder_c = ge_c ? WIDTH'(shifted_c - {1'b0, dvsr}) : shifted_c[WIDTH-1:0];
        quotient_c  = {quot[WIDTH-2:0], ge_c};
        done_c      = en & (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quot <= '0;
            dvsr <= '0;
            cnt  <= '0;
        end else if (start) begin
            rem  <= '0;
            quot <= dividend;
            dvsr <= divisor;
            cnt  <= '0;
        end else if (en) begin
            rem  <= remainder_c;
            quot <= quotient_c;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdu_core.sv
// EX-stage multiply/divide unit: owns HI/LO, runs iterative mul/div, services MT*/MF* moves.
module mdu_core
    import mdu_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_core_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state, state_nxt;
    logic               done, done_nxt;
    logic [CNT_W-1:0]   count;
    mdu_ctx_t           ctx;
    logic [WIDTH-1:0]   a_raw, mcand, hi, lo;
    logic [2*WIDTH-1:0] prod;

    logic [OP_W-1:0]    op;
    logic               accept_c, mt_wr_c, last_c, div_en_c, div_done_c;
    logic               a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_abs_c, b_abs_c, quot_c, rem_c, fin_hi_c, fin_lo_c, result_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [2*WIDTH-1:0] prod_step_c, prod_fix_c;

    assign op = bus.mdu_op_i;

    // Issue decode and operand magnitude/sign extraction.
    always_comb begin
        accept_c = (state == ST_IDLE) & bus.start_i & ~bus.flush_i & op_is_multi(op);
        mt_wr_c  = (state == ST_IDLE) & bus.start_i & ~bus.flush_i
                 & ((op == MDU_OP_MTHI) | (op == MDU_OP_MTLO));
        a_neg_c  = op_is_signed(op) & bus.a_i[WIDTH-1];
        b_neg_c  = op_is_signed(op) & bus.b_i[WIDTH-1];
        a_abs_c  = a_neg_c ? WIDTH'(-bus.a_i) : bus.a_i;
        b_abs_c  = b_neg_c ? WIDTH'(-bus.b_i) : bus.b_i;
        div_en_c = (state == ST_RUN) & op_is_div(ctx.op);
        last_c   = (state == ST_RUN) & (op_is_div(ctx.op) ? div_done_c : (count == LAST_CNT));
    end

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (accept_c),
        .en          (div_en_c),
        .dividend    (a_abs_c),
        .divisor     (b_abs_c),
        .quotient_c  (quot_c),
        .remainder_c (rem_c),
        .done_c      (div_done_c)
    );

    // Shift-add step; the final step and sign fix-up feed HI/LO directly on entry to DONE.
    always_comb begin
        mul_sum_c   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step_c = {mul_sum_c, prod[WIDTH-1:1]};
        prod_fix_c  = ctx.neg_res ? (2*WIDTH)'(-prod_step_c) : prod_step_c;
        fin_hi_c    = prod_fix_c[2*WIDTH-1:WIDTH];
        fin_lo_c    = prod_fix_c[WIDTH-1:0];
        if (op_is_div(ctx.op)) begin
            if (ctx.div_zero) begin
                fin_hi_c = a_raw;
                fin_lo_c = '1;
            end else begin
                fin_lo_c = ctx.neg_res ? WIDTH'(-quot_c) : quot_c;
                fin_hi_c = ctx.neg_rem ? WIDTH'(-rem_c) : rem_c;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: if (accept_c) state_nxt = ST_RUN;
            ST_RUN: begin
                if (last_c) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.flush_i) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ctx   <= '0;
            a_raw <= '0;
            mcand <= '0;
            prod  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept_c) begin
                count <= '0;
                ctx   <= '{op: mdu_op_e'(op), neg_res: a_neg_c ^ b_neg_c,
                           neg_rem: a_neg_c, div_zero: (bus.b_i == '0)};
                a_raw <= bus.a_i;
                mcand <= b_abs_c;
                prod  <= {{WIDTH{1'b0}}, a_abs_c};
            end else if (state == ST_RUN) begin
                count <= count + 1'b1;
                prod  <= prod_step_c;
            end
            if (done_nxt) begin
                hi <= fin_hi_c;
                lo <= fin_lo_c;
            end else if (mt_wr_c) begin
                if (op == MDU_OP_MTHI) hi <= bus.a_i;
                else                   lo <= bus.a_i;
            end
        end
    end

    // Writeback mux: moves read HI/LO directly; MUL presents LO in its DONE cycle.
    always_comb begin
        result_c = '0;
        if (bus.start_i && op == MDU_OP_MFHI)              result_c = hi;
        else if (bus.start_i && op == MDU_OP_MFLO)         result_c = lo;
        else if (state == ST_DONE && ctx.op == MDU_OP_MUL) result_c = lo;
    end

    assign bus.result_o = result_c;
    assign bus.stall_o  = (state == ST_RUN)
                        | ((state == ST_IDLE) & bus.start_i & op_is_multi(op))
                        | (bus.start_i & op_is_move(op) & (state == ST_RUN));
    assign bus.done_o   = done;
    assign bus.hi_o     = hi;
    assign bus.lo_o     = lo;

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: vector table through a scoreboard plus directed corner sequences.
module tb_mdu_core;
    import mdu_core_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         is_mul;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    mdu_core_if #(.WIDTH(W)) bus();
    mdu_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic start, input logic flush,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.mdu_op_i = op;
        bus.start_i  = start;
        bus.flush_i  = flush;
        bus.a_i      = a;
        bus.b_i      = b;
    endtask

    // Issue a multicycle op, hold it while stalled, and score HI/LO when done_o pulses.
    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   lat;
        logic got, stall_ok;
        e.hi = v.hi; e.lo = v.lo; e.is_mul = (v.op == MDU_OP_MUL);
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive(v.op, 1'b1, 1'b0, v.a, v.b);
        @(negedge clk);
        chk({name, " stall_on_accept"}, 64'(bus.stall_o), 64'd1);
        lat = 0; got = 1'b0; stall_ok = 1'b1;
        while (!got && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus.done_o) got = 1'b1;
            else if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
        end
        chk({name, " stall_held"}, 64'(stall_ok), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(W + 1));
        e = exp_q.pop_front();
        if (got) begin
            chk({name, " hi"}, 64'(bus.hi_o), 64'(e.hi));
            chk({name, " lo"}, 64'(bus.lo_o), 64'(e.lo));
            chk({name, " stall_in_done"}, 64'(bus.stall_o), 64'd0);
            if (e.is_mul) chk({name, " mul_result"}, 64'(bus.result_o), 64'(e.lo));
        end
        @(posedge clk); #1;
        drive(4'd0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    initial begin
        logic [W-1:0] prev_hi, prev_lo, ra, rb;
        longint       p;
        int           sa, sb, dq, dr;
        logic [63:0]  up;
        logic         saw_done;

        vecs.push_back(mk(MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk(MDU_OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB));
        vecs.push_back(mk(MDU_OP_MUL,   32'd6,        32'd7,        32'h00000000, 32'd42));
        vecs.push_back(mk(MDU_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000));
        vecs.push_back(mk(MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk(MDU_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk(MDU_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14));
        vecs.push_back(mk(MDU_OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF));
        vecs.push_back(mk(MDU_OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF));
        vecs.push_back(mk(MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000));
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            up = 64'(ra) * 64'(rb);
            vecs.push_back(mk(MDU_OP_MULTU, ra, rb, up[63:32], up[31:0]));
            sa = int'($urandom); sb = int'($urandom);
            p  = longint'(sa) * longint'(sb);
            vecs.push_back(mk(MDU_OP_MULT, W'(sa), W'(sb), W'(p >>> 32), W'(p)));
            ra = $urandom; rb = W'($urandom_range(1, 5000));
            vecs.push_back(mk(MDU_OP_DIVU, ra, rb, ra % rb, ra / rb));
            sa = int'($urandom); sb = int'($urandom_range(2, 5000));
            if ($urandom_range(0, 1) == 1) sb = -sb;
            dq = sa / sb; dr = sa % sb;
            vecs.push_back(mk(MDU_OP_DIV, W'(sa), W'(sb), W'(dr), W'(dq)));
        end

        drive(4'd0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset hi", 64'(bus.hi_o), 64'd0);
        chk("reset lo", 64'(bus.lo_o), 64'd0);
        chk("reset done", 64'(bus.done_o), 64'd0);
        chk("reset stall", 64'(bus.stall_o), 64'd0);
        chk("reset result", 64'(bus.result_o), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // MTLO then MFLO: no stall, value read back on the next instruction.
        @(posedge clk); #1 drive(MDU_OP_MTLO, 1'b1, 1'b0, 32'h1234, '0);
        @(negedge clk);
        chk("mtlo stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk); #1 drive(MDU_OP_MFLO, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("mflo result", 64'(bus.result_o), 64'h1234);
        chk("mflo stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk); #1 drive(MDU_OP_MTHI, 1'b1, 1'b0, 32'hAAAA, '0);
        @(posedge clk); #1 drive(MDU_OP_MFHI, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("mfhi result", 64'(bus.result_o), 64'hAAAA);

        // Unused op code: no stall, no result, HI/LO untouched.
        @(posedge clk); #1 drive(4'd12, 1'b1, 1'b0, 32'h55, 32'h66);
        @(negedge clk);
        chk("op12 stall", 64'(bus.stall_o), 64'd0);
        chk("op12 result", 64'(bus.result_o), 64'd0);
        @(posedge clk); #1 drive(4'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("op12 hilo", {bus.hi_o, bus.lo_o}, {32'hAAAA, 32'h1234});

        // Flush alongside MTHI: nothing written.
        @(posedge clk); #1 drive(MDU_OP_MTHI, 1'b1, 1'b1, 32'hDEAD, '0);
        @(posedge clk); #1 drive(4'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("flush mthi hi", 64'(bus.hi_o), 64'hAAAA);

        // MULT flushed at T+10: idle at T+11, no done pulse, HI/LO preserved.
        prev_hi = bus.hi_o; prev_lo = bus.lo_o;
        @(posedge clk); #1 drive(MDU_OP_MULT, 1'b1, 1'b0, 32'd9, 32'd9);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 drive(4'd0, 1'b0, 1'b1, '0, '0);
        @(posedge clk); #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush idle stall", 64'(bus.stall_o), 64'd0);
        saw_done = bus.done_o;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | bus.done_o;
        end
        chk("flush no done", 64'(saw_done), 64'd0);
        chk("flush hilo", {bus.hi_o, bus.lo_o}, {prev_hi, prev_lo});

        // MFHI presented during RUN: held by stall, then sees the new HI in DONE.
        @(posedge clk); #1 drive(MDU_OP_MULTU, 1'b1, 1'b0, 32'h10000, 32'h30000);
        @(posedge clk); #1 drive(MDU_OP_MFHI, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("mfhi run stall", 64'(bus.stall_o), 64'd1);
        begin
            int lat = 1;
            while (!bus.done_o && lat < 100) begin
                @(negedge clk); lat++;
            end
            chk("mfhi wait latency", 64'(lat), 64'(W + 1));
        end
        chk("mfhi done stall", 64'(bus.stall_o), 64'd0);
        chk("mfhi new hi", 64'(bus.result_o), 64'd3);
        @(posedge clk); #1 drive(4'd0, 1'b0, 1'b0, '0, '0);

        // Reset mid-operation returns everything to reset values.
        @(posedge clk); #1 drive(MDU_OP_DIVU, 1'b1, 1'b0, 32'd50, 32'd3);
        repeat (5) @(posedge clk);
        #1 begin rst = 1'b1; drive(4'd0, 1'b0, 1'b0, '0, '0); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("midrst stall", 64'(bus.stall_o), 64'd0);
        chk("midrst done", 64'(bus.done_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
